// File: rtl/rom_stream_ctrl.sv
// ROM burst reader: streams length words from start_addr through a 2-entry FIFO.
// Optional macro ROM_STREAM_WRAP_EN accepts bursts that wrap past the top of the ROM.
module rom_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  inflight_q, inflight_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q;

    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  head_last;
    logic                  reject;
    logic [2:0]            pressure;

`ifdef ROM_STREAM_WRAP_EN
    assign reject = 1'b0;
`else
    logic [ADDR_WIDTH:0] end_sum;
    assign end_sum = {1'b0, start_addr} + length;
    assign reject  = end_sum > {1'b1, {ADDR_WIDTH{1'b0}}};
`endif

    // Words the FIFO is already committed to hold, net of the one leaving now.
    assign pressure   = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue      = !rst && (state_q == RUN) && (pressure < 3'd2);
    assign last_issue = remain_q == (ADDR_WIDTH+1)'(1);
    assign head_last  = fifo_last_q[rd_ptr_q];
    assign pop        = m_valid && m_ready;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = start_addr;
                        remain_d = length;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - (ADDR_WIDTH+1)'(1);
                    if (last_issue) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remain_q        <= remain_d;
            done_q          <= done_d;
            err_q           <= err_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_issue;
            if (inflight_q) wr_ptr_q <= !wr_ptr_q;
            if (pop)        rd_ptr_q <= !rd_ptr_q;
            count_q         <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides validity, and m_data is masked when empty.
    always_ff @(posedge clk) begin
        if (!rst && inflight_q) begin
            fifo_data_q[wr_ptr_q] <= rom_data;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end
    end

    assign busy     = !rst && (state_q != IDLE);
    assign done     = !rst && done_q;
    assign err      = !rst && err_q;
    assign rom_en   = issue;
    assign rom_addr = rst ? '0 : addr_q;
    assign m_valid  = !rst && (count_q != 2'd0);
    assign m_data   = m_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign m_last   = m_valid && head_last;

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Scoreboard bench for rom_stream_ctrl: expected addresses and words are queued at start,
// then checked as the DUT issues reads and pops words.
module tb_rom_stream_ctrl;

    localparam int DW = 8;
    localparam int AW = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done, err, rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;

    int vectors     = 0;
    int miscompares = 0;

    word_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    word_t         exp_w;
    logic [AW-1:0] exp_a;
    int            cyc = 0, last_pop_cyc = -1, pops = 0, issued = 0, popped = 0;
    bit            ready_toggle = 1'b0;
    bit            stalled = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    always #5 clk = ~clk;

    rom_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .err(err), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a ^ (a >> 3) ^ 10'h15A;
        return t[DW-1:0];
    endfunction

    // One-cycle-latency ROM.
    always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);

    // Cycle counter and ready pattern 1,0,0,1 when toggling.
    initial m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        cyc++;
        m_ready = ready_toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_en) begin
                issued++;
                vectors++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rom_addr: unexpected read at %h, none expected", rom_addr);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (rom_addr !== exp_a) begin
                        miscompares++;
                        $display("FAIL rom_addr: got %h expected %h", rom_addr, exp_a);
                    end
                end
            end
            if (stalled) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             m_valid, m_data, m_last, hold_data, hold_last);
                end
            end
            if (m_valid && m_ready) begin
                popped++;
                pops++;
                last_pop_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL m_data: unexpected word %h, none expected", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (m_data !== exp_w.data || m_last !== exp_w.last) begin
                        miscompares++;
                        $display("FAIL m_data: got %h/last=%b expected %h/last=%b",
                                 m_data, m_last, exp_w.data, exp_w.last);
                    end
                end
            end
            if (rom_en) begin
                vectors++;
                if (issued - popped > 2) begin
                    miscompares++;
                    $display("FAIL read_ahead: got %0d outstanding expected <= 2", issued - popped);
                end
            end
            stalled   = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic pulse_start(input logic [AW-1:0] sa, input int len, input bit push);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = sa;
        length     = (AW+1)'(len);
        if (push) begin
            for (int i = 0; i < len; i++) begin
                addr_q.push_back(AW'(sa + i));
                exp_q.push_back('{data: rom_word(AW'(sa + i)), last: (i == len - 1)});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({busy, done, err, rom_en, rom_addr, m_valid, m_data, m_last} !== '0) begin
            miscompares++;
            $display("FAIL %s: got busy=%b done=%b err=%b rom_en=%b addr=%h v=%b d=%h l=%b expected all 0",
                     name, busy, done, err, rom_en, rom_addr, m_valid, m_data, m_last);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_done: got no done expected done within 300 cycles", name);
        end else begin
            vectors++;
            if (exp_q.size() != 0 || addr_q.size() != 0 || last_pop_cyc != cyc - 1) begin
                miscompares++;
                $display("FAIL %s_done: got words_left=%0d addrs_left=%0d pop_to_done=%0d expected 0 0 1",
                         name, exp_q.size(), addr_q.size(), cyc - last_pop_cyc);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_after: got done=%b busy=%b expected 0 0", name, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_addr = '0; length = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_reset_idle");
    endtask

    task automatic test_basic();
        int  lat = 1;
        int  first;
        bit  seen = 1'b0;
        pulse_start(10'h010, 4, 1'b1);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
            else lat++;
        end
        first = cyc;
        vectors++;
        if (!seen || lat != 3 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_valid: got latency=%0d busy=%b expected 3 1", lat, busy);
        end
        wait_done("basic");
        vectors++;
        if (last_pop_cyc != first + 3) begin
            miscompares++;
            $display("FAIL throughput: got last pop %0d cycles after first expected 3",
                     last_pop_cyc - first);
        end
    endtask

    task automatic test_backpressure();
        ready_toggle = 1'b1;
        pulse_start(10'h123, 3, 1'b1);
        wait_done("backpressure");
        ready_toggle = 1'b0;
    endtask

    task automatic test_wrap();
`ifdef ROM_STREAM_WRAP_EN
        pulse_start(10'h3FE, 4, 1'b1);
        wait_done("wrap");
`else
        pulse_start(10'h3FE, 4, 1'b0);
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_reject: got err=%b busy=%b expected 1 0", err, busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_quiet: got err=%b busy=%b done=%b v=%b expected 0 0 0 0",
                         err, busy, done, m_valid);
            end
        end
`endif
        pulse_start(10'h3FC, 4, 1'b1);
        wait_done("top_boundary");
    endtask

    task automatic test_zero_and_busy();
        pulse_start(10'h055, 0, 1'b1);
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len: got done=%b busy=%b v=%b expected 1 0 0", done, busy, m_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_len_quiet: got done=%b v=%b expected 0 0", done, m_valid);
            end
        end
        pulse_start(10'h200, 8, 1'b1);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy: got %b expected 1", busy);
        end
        pulse_start(10'h000, 5, 1'b0);
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start_err: got %b expected 0", err);
        end
        wait_done("busy_ignore");
        repeat (6) @(negedge clk);
        vectors++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_quiet: got v=%b busy=%b expected 0 0", m_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        bit seen = 1'b0;
        pulse_start(10'h080, 8, 1'b1);
        p0 = pops;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (pops >= p0 + 2) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_mid_progress: got %0d pops expected 2", pops - p0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        popped = 0;
        @(negedge clk);
        check_zero("reset_mid_during");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet: got done=%b v=%b busy=%b expected 0 0 0",
                         done, m_valid, busy);
            end
        end
        pulse_start(10'h100, 2, 1'b1);
        wait_done("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_busy();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_stream_ctrl.md
ROM_STREAM_CTRL -- requirements
Module: rom_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: ROM word and stream data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10: ROM address width, for a 1024-word ROM.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: burst request; it is sampled only when busy=0.
REQ-006 The block SHALL have port start_addr, input, ADDR_WIDTH bits: first ROM address of the burst.
REQ-007 The block SHALL have port length, input, ADDR_WIDTH+1 bits: burst word count, from 0 to 1024.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the cycle after a start is accepted until done.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse when a burst completes.
REQ-010 The block SHALL have port err, output, 1 bit: single-cycle pulse when a request is rejected (see Configuration).
REQ-011 The block SHALL have port rom_en, output, 1 bit: ROM read strobe.
REQ-012 The block SHALL have port rom_addr, output, ADDR_WIDTH bits: ROM read address.
REQ-013 The block SHALL have port rom_data, input, DATA_WIDTH bits: ROM read data, valid exactly one cycle after rom_en.
REQ-014 The block SHALL have port m_valid, output, 1 bit; port m_ready, input, 1 bit; port m_data, output, DATA_WIDTH bits; and port m_last, output, 1 bit. m_last marks the final word of a burst.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DRAIN; done SHALL pulse on the transition DRAIN->IDLE or the transition IDLE->IDLE (zero length).
REQ-016 In IDLE, start=1 with length>0 SHALL load the address counter with start_addr and the remaining-issue counter with length, then enter RUN.
REQ-017 In IDLE, start=1 with length=0 SHALL pulse done in the next cycle, issue no ROM reads and produce no stream words.
REQ-018 In RUN, rom_en SHALL be asserted only when (FIFO occupancy + reads in flight − pop this cycle) < 2.
REQ-019 Each rom_en SHALL increment the address and decrement the remaining-issue count.
REQ-020 After the last read is issued, the FSM SHALL enter DRAIN.
REQ-021 A 2-entry output FIFO SHALL capture rom_data in the cycle after rom_en; a pop SHALL occur when m_valid and m_ready are both high.
REQ-022 m_valid SHALL equal FIFO-not-empty; m_data and m_last SHALL be stable while m_valid=1 and m_ready=0.
REQ-023 m_last SHALL be 1 only on the word that is the length-th word of the burst.
REQ-024 DRAIN SHALL return to IDLE, pulsing done, in the cycle after the m_last word pops.
REQ-025 With m_ready held high, the first m_valid SHALL occur 3 cycles after the start cycle, and throughput SHALL then be 1 word/cycle.
REQ-026 start while busy=1 SHALL be ignored, with no err.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_WIDTH.

Reset
REQ-028 rst=1 SHALL force IDLE within one edge and clear the FIFO, the in-flight flag and the counters.
REQ-029 During reset, outputs SHALL be busy=0, done=0, err=0, rom_en=0, rom_addr=0, m_valid=0, m_data=0 and m_last=0.
REQ-030 Reset mid-burst SHALL discard all pending words; rom_data returning after reset SHALL be ignored; done SHALL not pulse.

Configuration
REQ-031 When the macro ROM_STREAM_WRAP_EN is defined, a burst with start_addr+length > 2^ADDR_WIDTH SHALL be accepted, and the address SHALL wrap from 1023 to 0.
REQ-032 When ROM_STREAM_WRAP_EN is undefined, such a burst SHALL be rejected: err pulses in the next cycle, the FSM stays in IDLE, and there is no ROM access and no done.
REQ-033 start_addr+length = 2^ADDR_WIDTH exactly SHALL be legal in both builds.

Verification
REQ-034 Scenario 1: start_addr=0x010, length=4, m_ready=1 -> rom_addr 0x010..0x013 on consecutive cycles; m_valid first seen 3 cycles after start; 4 words with m_last on the 4th; done the cycle after.
REQ-035 Scenario 2: length=3, m_ready toggling 1,0,0,1,... -> no word lost or duplicated; m_data held while stalled; rom_en never issues more than 2 words beyond pops.
REQ-036 Scenario 3: start_addr=0x3FE, length=4 -> with ROM_STREAM_WRAP_EN, addresses 0x3FE, 0x3FF, 0x000, 0x001; without it, err pulse, busy stays 0.
REQ-037 Scenario 4: length=0 -> done pulse next cycle, m_valid stays 0; a second start asserted while busy during a length=8 burst -> ignored.
REQ-038 Scenario 5: rst asserted after 2 of 8 words -> all outputs 0 next cycle; a new burst at 0x100, length=2 streams correctly with no stale data.
